// File: rtl/button_ctrl_pkg.sv
// Shared types, register offsets and helpers for the push-button peripheral.
package button_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned POP_W   = 5;

    localparam logic [1:0] BTN_OFF_LEVEL = 2'd0;
    localparam logic [1:0] BTN_OFF_PRESS = 2'd1;
    localparam logic [1:0] BTN_OFF_COUNT = 2'd2;
    localparam logic [1:0] BTN_OFF_MASK  = 2'd3;

    typedef enum logic [1:0] {
        DB_STABLE_LO = 2'd0,
        DB_WAIT_HI   = 2'd1,
        DB_STABLE_HI = 2'd2,
        DB_WAIT_LO   = 2'd3
    } db_state_e;

    // Number of set bits in a (zero-extended) button vector.
    function automatic logic [POP_W-1:0] popcount16(input logic [15:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM with hold counter, level and press pulse.
module btn_debounce
    import button_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 200000,
    parameter int unsigned CNT_W     = 18
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_button,
    output logic o_level,
    output logic o_press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       r_sync;
    db_state_e        r_state;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             w_sync;

    assign w_sync        = r_sync[1];
    assign o_level       = r_level;
    assign o_press_pulse = r_pulse;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync  <= '0;
            r_state <= DB_STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_button};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // A changed input must persist DB_CYCLES cycles in WAIT_x; any revert discards it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
        case (r_state)
            DB_STABLE_LO: begin
                if (w_sync) begin
                    w_state_nxt = DB_WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            DB_WAIT_HI: begin
                if (!w_sync) begin
                    w_state_nxt = DB_STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DB_STABLE_HI: begin
                if (!w_sync) begin
                    w_state_nxt = DB_WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            DB_WAIT_LO: begin
                if (w_sync) begin
                    w_state_nxt = DB_STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/button_ctrl.sv
// Push-button bus responder: debounced LEVEL, W1C PRESS flags, press COUNT.
// Optional masked level interrupt and MASK register when BTN_IRQ_EN is defined.
module button_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BTN   = 5,
    parameter int unsigned DB_CYCLES = 200000,
    parameter int unsigned CNT_W     = 18
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_BTN-1:0]  button,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [DATA_W-1:0]   wdata,
`ifdef BTN_IRQ_EN
    output logic [DATA_W-1:0]   rdata,
    output logic                irq
`else
    output logic [DATA_W-1:0]   rdata
`endif
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_pulse;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] w_clr;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_add;
    logic               w_sel_press;
    logic               w_sel_count;
    logic [DATA_W-NUM_BTN+1:0] w_unused_bits;

    assign w_unused_bits = {addr[1:0], wdata[DATA_W-1:NUM_BTN]};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk           (clk),
            .rstn          (rstn),
            .i_button      (button[g]),
            .o_level       (w_level[g]),
            .o_press_pulse (w_pulse[g])
        );
    end

    assign w_sel_press = we && (addr[3:2] == BTN_OFF_PRESS);
    assign w_sel_count = we && (addr[3:2] == BTN_OFF_COUNT);
    assign w_clr       = w_sel_press ? wdata[NUM_BTN-1:0] : '0;
    assign w_count_add = COUNT_W'(popcount16(16'(w_pulse)));

    // New press pulses override a same-cycle W1C; a COUNT store clears before adding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_press <= '0;
            r_count <= '0;
        end else begin
            r_press <= (r_press & ~w_clr) | w_pulse;
            r_count <= w_sel_count ? w_count_add : (r_count + w_count_add);
        end
    end

`ifdef BTN_IRQ_EN
    logic [NUM_BTN-1:0] r_mask;
    logic               r_irq;

    assign irq = r_irq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (we && (addr[3:2] == BTN_OFF_MASK)) begin
                r_mask <= wdata[NUM_BTN-1:0];
            end
            r_irq <= |(r_press & r_mask);
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            BTN_OFF_LEVEL: rdata = DATA_W'(w_level);
            BTN_OFF_PRESS: rdata = DATA_W'(r_press);
            BTN_OFF_COUNT: rdata = DATA_W'(r_count);
`ifdef BTN_IRQ_EN
            BTN_OFF_MASK:  rdata = DATA_W'(r_mask);
`else
            BTN_OFF_MASK:  rdata = '0;
`endif
        endcase
    end

endmodule

// File: tb/tb_button_ctrl.sv
// Directed self-checking bench for button_ctrl with DB_CYCLES=4 (BTN_IRQ_EN optional).
module tb_button_ctrl;

    logic        clk;
    logic        rstn;
    logic [4:0]  button;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
`ifdef BTN_IRQ_EN
    logic        irq;
`endif

    int n_pass;
    int n_fail;
    int n_total;

    button_ctrl #(
        .NUM_BTN   (5),
        .DB_CYCLES (4),
        .CNT_W     (18)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .button (button),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
`ifdef BTN_IRQ_EN
        .rdata  (rdata),
        .irq    (irq)
`else
        .rdata  (rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic store(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
        wdata = '0;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        rstn = 1'b0; button = '0; addr = '0; we = 1'b0; wdata = '0;
        tick(2);
        chk_reg("rst_level", 4'h0, 32'h0);
        chk_reg("rst_press", 4'h4, 32'h0);
        chk_reg("rst_count", 4'h8, 32'h0);
        rstn = 1'b1;
        tick(3);

        // single press on btn0: level after exactly 7 edges, flag and count one edge later
        button = 5'b00001;
        tick(6);
        chk_reg("b0_level_at6", 4'h0, 32'h00);
        tick(1);
        chk_reg("b0_level_at7", 4'h0, 32'h01);
        chk_reg("b0_press_at7", 4'h4, 32'h00);
        tick(1);
        chk_reg("b0_press", 4'h4, 32'h01);
        chk_reg("b0_count", 4'h8, 32'h1);
        tick(3);
        chk_reg("b0_press_noclr_on_read", 4'h4, 32'h01);
        button = 5'b00000;
        tick(10);
        chk_reg("b0_release_level", 4'h0, 32'h00);
        chk_reg("b0_release_count", 4'h8, 32'h1);

        // btn2 glitches of 1 and 3 cycles are discarded
        button = 5'b00100; tick(1); button = 5'b00000; tick(10);
        chk_reg("g1_level", 4'h0, 32'h00);
        chk_reg("g1_press", 4'h4, 32'h01);
        chk_reg("g1_count", 4'h8, 32'h1);
        button = 5'b00100; tick(3); button = 5'b00000; tick(10);
        chk_reg("g3_level", 4'h0, 32'h00);
        chk_reg("g3_press", 4'h4, 32'h01);
        chk_reg("g3_count", 4'h8, 32'h1);

        // stores to LEVEL are ignored
        store(4'h0, 32'hFFFF_FFFF);
        chk_reg("level_store_ignored", 4'h0, 32'h00);

        // simultaneous btn1+btn3 presses, then partial W1C
        store(4'h4, 32'h1F);
        chk_reg("w1c_all", 4'h4, 32'h00);
        button = 5'b01010;
        tick(8);
        chk_reg("b13_level", 4'h0, 32'h0A);
        chk_reg("b13_press", 4'h4, 32'h0A);
        chk_reg("b13_count", 4'h8, 32'h3);
        store(4'h4, 32'h02);
        chk_reg("b13_w1c_bit1", 4'h4, 32'h08);
        button = 5'b00000;
        tick(10);
        chk_reg("b13_release_level", 4'h0, 32'h00);

        // W1C of bit0 lands on the same edge the new btn0 pulse sets it: set wins
        button = 5'b00001;
        tick(7);
        store(4'h4, 32'h01);
        chk_reg("set_wins_press", 4'h4, 32'h09);
        chk_reg("set_wins_count", 4'h8, 32'h4);
        button = 5'b00000;
        tick(10);

        // COUNT store on the same edge as a press: clear then add
        button = 5'b00100;
        tick(7);
        store(4'h8, 32'h0);
        chk_reg("count_store_with_press", 4'h8, 32'h1);
        button = 5'b00000;
        tick(10);

        // COUNT wraps 0xFFFF -> 0x0000; store clears
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        chk_reg("count_preload", 4'h8, 32'hFFFF);
        tick(1);
        button = 5'b00010;
        tick(8);
        chk_reg("count_wrap", 4'h8, 32'h0);
        button = 5'b00000;
        tick(10);
        store(4'h4, 32'h1F);
        button = 5'b01000;
        tick(8);
        chk_reg("count_after_wrap", 4'h8, 32'h1);
        store(4'h8, 32'h1234);
        chk_reg("count_store_clears", 4'h8, 32'h0);
        button = 5'b00000;
        tick(10);

        // reset during WAIT_HI aborts it; held button re-debounces after release
        button = 5'b10000;
        tick(4);
        rstn = 1'b0;
        tick(1);
        chk_reg("midrst_level", 4'h0, 32'h00);
        chk_reg("midrst_press", 4'h4, 32'h00);
        chk_reg("midrst_count", 4'h8, 32'h0);
        tick(1);
        rstn = 1'b1;
        tick(6);
        chk_reg("postrst_level_at6", 4'h0, 32'h00);
        tick(1);
        chk_reg("postrst_level_at7", 4'h0, 32'h10);
        tick(1);
        chk_reg("postrst_press", 4'h4, 32'h10);
        chk_reg("postrst_count", 4'h8, 32'h1);

`ifdef BTN_IRQ_EN
        store(4'h4, 32'h1F);
        button = 5'b00000;
        tick(10);
        chk_reg("mask_reset", 4'hC, 32'h00);
        store(4'hC, 32'h10);
        chk_reg("mask_write", 4'hC, 32'h10);
        check("irq_idle", 32'(irq), 32'h0);
        button = 5'b10000;
        tick(8);
        chk_reg("irq_press_set", 4'h4, 32'h10);
        check("irq_same_edge_as_flag", 32'(irq), 32'h0);
        tick(1);
        check("irq_asserted", 32'(irq), 32'h1);
        store(4'h4, 32'h10);
        check("irq_hold_on_clear_edge", 32'(irq), 32'h1);
        tick(1);
        check("irq_cleared", 32'(irq), 32'h0);
`else
        store(4'hC, 32'h1F);
        chk_reg("mask_absent_reads0", 4'hC, 32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
